// File: rtl/nf_i_lsu.sv
// Load/store unit: one req/ack data-memory access per instruction, stalling the pipeline meanwhile.
// Optional misaligned-access trap is enabled by defining NF_LSU_MISALIGN_EN.
module nf_i_lsu (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wd,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [1:0]  l_size,
    input  logic        l_unsigned,
    output logic [31:0] l_rd,
    output logic        l_rd_valid,
    output logic        lsu_busy,
`ifdef NF_LSU_MISALIGN_EN
    output logic        l_misalign,
`endif
    output logic [31:0] addr_dm,
    output logic [31:0] wd_dm,
    output logic [3:0]  be_dm,
    output logic        we_dm,
    output logic        req_dm,
    input  logic        req_ack_dm,
    input  logic [31:0] rd_dm
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic        req_q, req_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rd_q, rd_d;
    logic        rd_valid_q, rd_valid_d;
`ifdef NF_LSU_MISALIGN_EN
    logic        mis_q, mis_d;
    logic        mis_new;
`endif

    logic [3:0]  be_new;
    logic [31:0] wd_new;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_ext;

    // Lane decode of the incoming request
    always_comb begin
        be_new = 4'b1111;
        wd_new = l_wd;
        case (l_size)
            2'b00: begin
                be_new = 4'b0001 << l_addr[1:0];
                wd_new = {4{l_wd[7:0]}};
            end
            2'b01: begin
                be_new = 4'b0011 << {l_addr[1], 1'b0};
                wd_new = {2{l_wd[15:0]}};
            end
            default: begin
                be_new = 4'b1111;
                wd_new = l_wd;
            end
        endcase
    end

`ifdef NF_LSU_MISALIGN_EN
    assign mis_new = ((l_size == 2'b01) && l_addr[0]) || (l_size[1] && (l_addr[1:0] != 2'b00));
`endif

    // Load extraction uses the lane of the registered address
    always_comb begin
        case (addr_q[1:0])
            2'b00:   byte_sel = rd_dm[7:0];
            2'b01:   byte_sel = rd_dm[15:8];
            2'b10:   byte_sel = rd_dm[23:16];
            default: byte_sel = rd_dm[31:24];
        endcase
        half_sel = addr_q[1] ? rd_dm[31:16] : rd_dm[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   ld_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: ld_ext = rd_dm;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        be_d       = be_q;
        we_d       = we_q;
        req_d      = req_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rd_d       = rd_q;
        rd_valid_d = 1'b0;
`ifdef NF_LSU_MISALIGN_EN
        mis_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (l_req) begin
`ifdef NF_LSU_MISALIGN_EN
                    if (mis_new) begin
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else
`endif
                    begin
                        addr_d  = l_addr;
                        wd_d    = wd_new;
                        be_d    = be_new;
                        we_d    = l_we;
                        size_d  = l_size;
                        uns_d   = l_unsigned;
                        req_d   = 1'b1;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (req_ack_dm) begin
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    rd_valid_d = ~we_q;
                    if (!we_q) rd_d = ld_ext;
                    state_d    = DONE;
                end
            end
            // l_req in DONE still belongs to the finished instruction
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wd_q       <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            req_q      <= 1'b0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
`ifdef NF_LSU_MISALIGN_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            be_q       <= be_d;
            we_q       <= we_d;
            req_q      <= req_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
`ifdef NF_LSU_MISALIGN_EN
            mis_q      <= mis_d;
`endif
        end
    end

    assign lsu_busy   = ((state_q == IDLE) && l_req) || (state_q == ACCESS);
    assign l_rd       = rd_q;
    assign l_rd_valid = rd_valid_q;
    assign addr_dm    = addr_q;
    assign wd_dm      = wd_q;
    assign be_dm      = be_q;
    assign we_dm      = we_q;
    assign req_dm     = req_q;
`ifdef NF_LSU_MISALIGN_EN
    assign l_misalign = mis_q;
`endif

endmodule
